// File: rtl/adc_stream_framer.sv
// adc_stream_framer: reduces an ADC sample stream by decimation or
// power-of-two averaging, buffers the reduced samples in a small FIFO and
// sends them as framed, checksummed byte packets over a valid/ready byte port.
module adc_stream_framer #(
   parameter int SAMPLE_W      = 12,
   parameter int DECIM         = 2000,
   parameter int AVG_LOG2      = 2,
   parameter int FRAME_SAMPLES = 16,
   parameter int FIFO_ABITS    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SAMPLE_W-1:0]   sample_i,
   input  logic                  sample_valid_i,
   input  logic                  mode_i,
   input  logic                  clear_ovf_i,
   output logic [7:0]            byte_o,
   output logic                  byte_valid_o,
   input  logic                  byte_ready_i,
   output logic                  overflow_o,
   output logic [FIFO_ABITS:0]   fifo_level_o
);

   localparam int GRP_MAX = (DECIM > (1 << AVG_LOG2)) ? DECIM : (1 << AVG_LOG2);
   localparam int CNT_W   = $clog2(GRP_MAX) + 1;
   localparam int ACC_W   = SAMPLE_W + AVG_LOG2;
   localparam int DEPTH   = 1 << FIFO_ABITS;
   localparam logic [CNT_W-1:0]    DEC_LAST   = CNT_W'(DECIM - 1);
   localparam logic [CNT_W-1:0]    AVG_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
   localparam logic [FIFO_ABITS:0] PTR_ONE    = (FIFO_ABITS + 1)'(1);
   localparam logic [FIFO_ABITS:0] FULL_LVL   = (FIFO_ABITS + 1)'(DEPTH);
   localparam logic [7:0]          FRAME_LAST = 8'(FRAME_SAMPLES - 1);

   typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, MSB, LSB, CSUM} state_t;

   // Group average: drop the low AVG_LOG2 bits (truncation, no rounding).
   function automatic logic [SAMPLE_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] s;
      s = a >> AVG_LOG2;
      return s[SAMPLE_W-1:0];
   endfunction

   // Samples travel on the wire zero-extended to 16 bits.
   function automatic logic [15:0] zext16(input logic [SAMPLE_W-1:0] d);
      logic [15:0] z;
      z = '0;
      z[SAMPLE_W-1:0] = d;
      return z;
   endfunction

   // ---- stage p0: group counting and reduction ----
   logic [CNT_W-1:0]    grp_cnt;
   logic                mode_q;
   logic [ACC_W-1:0]    acc_p0;
   logic                grp_first, grp_last, mode_eff;
   logic [ACC_W-1:0]    acc_sum;
   logic                vld_p0;
   logic [SAMPLE_W-1:0] data_p0;

   // A new group takes mode_i directly; later samples use the latched mode.
   always_comb begin
      grp_first = (grp_cnt == '0);
      mode_eff  = grp_first ? mode_i : mode_q;
      grp_last  = mode_eff ? (grp_cnt == AVG_LAST) : (grp_cnt == DEC_LAST);
      acc_sum   = (grp_first ? '0 : acc_p0) + ACC_W'(sample_i);
      vld_p0    = sample_valid_i && (mode_eff ? grp_last : grp_first);
      data_p0   = mode_eff ? avg_trunc(acc_sum) : sample_i;
   end

   // Advance the group position, latch the mode and accumulate on each strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_cnt <= '0;
         mode_q  <= 1'b0;
         acc_p0  <= '0;
      end else if (sample_valid_i) begin
         if (grp_first) mode_q <= mode_i;
         grp_cnt <= grp_last ? '0 : grp_cnt + CNT_ONE;
         acc_p0  <= acc_sum;
      end
   end

   // ---- stage p1: sample FIFO (first-word fall-through) ----
   logic [SAMPLE_W-1:0]   mem [DEPTH];
   logic [FIFO_ABITS:0]   wr_ptr, rd_ptr;
   logic [FIFO_ABITS-1:0] rd_idx, rd_nxt_idx;
   logic                  fifo_empty, fifo_full, pop, push_ok, drop;
   logic [15:0]           head16, nxt16;
   state_t                state;

   assign fifo_level_o = wr_ptr - rd_ptr;
   assign fifo_empty   = (fifo_level_o == '0);
   assign fifo_full    = (fifo_level_o == FULL_LVL);
   assign rd_idx       = rd_ptr[FIFO_ABITS-1:0];
   assign rd_nxt_idx   = rd_idx + FIFO_ABITS'(1);
   assign head16       = zext16(mem[rd_idx]);
   assign nxt16        = zext16(mem[rd_nxt_idx]);
   assign pop          = (state == LSB) && byte_valid_o && byte_ready_i;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok      = vld_p0 && (!fifo_full || pop);
   assign drop         = vld_p0 && fifo_full && !pop;

   // Sample storage; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[FIFO_ABITS-1:0]] <= data_p0;
   end

   // FIFO pointers and the sticky overflow flag (a drop beats a clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         if (drop)             overflow_o <= 1'b1;
         else if (clear_ovf_i) overflow_o <= 1'b0;
      end
   end

   // ---- stage p2: framer ----
   logic [7:0] seq, sent_cnt, csum;
   logic       xfer;

   assign xfer = byte_valid_o && byte_ready_i;

   // Framer FSM: the registered byte is always the one the current state sends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         byte_o       <= 8'h00;
         byte_valid_o <= 1'b0;
         seq          <= 8'h00;
         sent_cnt     <= 8'h00;
         csum         <= 8'h00;
      end else begin
         case (state)
            IDLE: if (!fifo_empty) begin
               state        <= SYNC0;
               byte_o       <= 8'hA5;
               byte_valid_o <= 1'b1;
            end
            SYNC0: if (xfer) begin
               state  <= SYNC1;
               byte_o <= 8'h5A;
            end
            SYNC1: if (xfer) begin
               state  <= SEQ;
               byte_o <= seq;
               csum   <= seq;
            end
            SEQ: if (xfer) begin
               state        <= MSB;
               sent_cnt     <= 8'h00;
               byte_o       <= head16[15:8];
               byte_valid_o <= !fifo_empty;
            end
            MSB: begin
               if (!byte_valid_o) begin
                  if (!fifo_empty) begin
                     byte_o       <= head16[15:8];
                     byte_valid_o <= 1'b1;
                  end
               end else if (xfer) begin
                  state  <= LSB;
                  byte_o <= head16[7:0];
                  csum   <= csum ^ byte_o;
               end
            end
            LSB: if (xfer) begin
               csum <= csum ^ byte_o;
               if (sent_cnt == FRAME_LAST) begin
                  state  <= CSUM;
                  byte_o <= csum ^ byte_o;
               end else begin
                  // Look past the entry being popped so the next MSB goes out without a bubble.
                  state        <= MSB;
                  sent_cnt     <= sent_cnt + 8'd1;
                  byte_o       <= nxt16[15:8];
                  byte_valid_o <= (fifo_level_o > PTR_ONE);
               end
            end
            CSUM: if (xfer) begin
               state        <= IDLE;
               seq          <= seq + 8'd1;
               byte_valid_o <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               byte_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_stream_framer.sv
// Testbench for adc_stream_framer: scenario tasks with a queue-based reference
// model that derives reduced samples and frame bytes from the stream rules.
module tb_adc_stream_framer;
   localparam int SW = 12, DEC = 4, AL = 2, FS = 2, FA = 2;
   localparam int FB = 2 * FS + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] sample_i;
   logic          sample_valid_i, mode_i, clear_ovf_i, byte_ready_i;
   logic [7:0]    byte_o;
   logic          byte_valid_o, overflow_o;
   logic [FA:0]   fifo_level_o;

   int n_checks = 0, n_fail = 0, cyc = 0;
   logic [7:0] got[$];
   int         got_cyc[$];
   int         red_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] exp_dec[8] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
   logic [7:0] exp_avg[8] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h0F, 8'hFF, 8'hF2};
   int         avg_in[8]  = '{1, 2, 3, 5, 4095, 4095, 4095, 4095};

   adc_stream_framer #(.SAMPLE_W(SW), .DECIM(DEC), .AVG_LOG2(AL),
                       .FRAME_SAMPLES(FS), .FIFO_ABITS(FA)) dut (
      .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
      .mode_i(mode_i), .clear_ovf_i(clear_ovf_i), .byte_o(byte_o),
      .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
      .overflow_o(overflow_o), .fifo_level_o(fifo_level_o));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte sink: records every transfer, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst && byte_valid_o && byte_ready_i) begin
         got.push_back(byte_o);
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_valid_i = 1'b0; sample_i = '0; mode_i = 1'b0; clear_ovf_i = 1'b0;
      byte_ready_i = 1'b0;
      step(); step();
      rst = 1'b0;
      got.delete(); got_cyc.delete(); red_q.delete();
   endtask

   task automatic feed(input int s, input int m);
      sample_i = SW'(s);
      mode_i = 1'(m);
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      for (int c = 0; c < budget && got.size() < n; c++) step();
   endtask

   // Reference frames: A5 5A seq, each sample as MSB/LSB, XOR of seq and sample bytes.
   task automatic build_expected(input int seq0);
      int nfr;
      logic [7:0] sq, cs, hi, lo;
      exp_q.delete();
      nfr = red_q.size() / FS;
      for (int f = 0; f < nfr; f++) begin
         sq = 8'((seq0 + f) % 256);
         exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(sq);
         cs = sq;
         for (int k = 0; k < FS; k++) begin
            hi = 8'(red_q[f * FS + k] / 256);
            lo = 8'(red_q[f * FS + k] % 256);
            exp_q.push_back(hi); exp_q.push_back(lo);
            cs = cs ^ hi ^ lo;
         end
         exp_q.push_back(cs);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sample_valid_i = 1'b0; sample_i = '0; mode_i = 1'b0; clear_ovf_i = 1'b0;
      byte_ready_i = 1'b1;
      #2;
      n_checks++; if (byte_o !== 8'h00) begin n_fail++; $display("FAIL rst_byte got %h want 00", byte_o); end
      n_checks++; if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", byte_valid_o); end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow_o); end
      n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", fifo_level_o); end
      step();
      rst = 1'b0;
      got.delete(); got_cyc.delete();
      for (int i = 0; i < 8; i++) feed(i, 0);
      // Mid-frame asynchronous reset, away from any clock edge.
      #1 rst = 1'b1;
      #1;
      n_checks++; if (byte_valid_o !== 1'b0 || byte_o !== 8'h00) begin
         n_fail++; $display("FAIL midrst_out got v=%b b=%h want v=0 b=00", byte_valid_o, byte_o); end
      n_checks++; if (fifo_level_o !== 3'd0 || overflow_o !== 1'b0) begin
         n_fail++; $display("FAIL midrst_fifo got lvl=%0d ovf=%b want 0 0", fifo_level_o, overflow_o); end
      step(); step();
      rst = 1'b0;
      got.delete(); got_cyc.delete();
      for (int i = 0; i < 8; i++) feed(i, 0);
      wait_bytes(FB, 40);
      n_checks++; if (got.size() != FB) begin n_fail++; $display("FAIL postrst_count got %0d want %0d", got.size(), FB); end
      else begin
         n_checks++; if (got[0] !== 8'hA5 || got[2] !== 8'h00) begin
            n_fail++; $display("FAIL postrst_seq got %h/%h want a5/00", got[0], got[2]); end
      end
   endtask

   task automatic test_decimate();
      int c0;
      do_reset();
      byte_ready_i = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
         feed(i, 0);
         if (i == 0) begin
            n_checks++; if (fifo_level_o !== 3'd1) begin n_fail++; $display("FAIL dec_push_lat got %0d want 1", fifo_level_o); end
         end
      end
      wait_bytes(8, 40);
      n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL dec_count got %0d want 8", got.size()); end
      else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++; if (got[i] !== exp_dec[i]) begin n_fail++; $display("FAIL dec_byte%0d got %h want %h", i, got[i], exp_dec[i]); end
         end
         n_checks++; if (got_cyc[0] != c0 + 2) begin n_fail++; $display("FAIL dec_idle_exit got cycle %0d want %0d", got_cyc[0], c0 + 2); end
         n_checks++; if (got_cyc[7] - got_cyc[0] != 7) begin n_fail++; $display("FAIL dec_b2b got span %0d want 7", got_cyc[7] - got_cyc[0]); end
      end
   endtask

   task automatic test_average();
      do_reset();
      byte_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) feed(avg_in[i], 1);
      wait_bytes(8, 40);
      n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL avg_count got %0d want 8", got.size()); end
      else for (int i = 0; i < 8; i++) begin
         n_checks++; if (got[i] !== exp_avg[i]) begin n_fail++; $display("FAIL avg_byte%0d got %h want %h", i, got[i], exp_avg[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic pv, pr;
      logic [7:0] pb;
      do_reset();
      byte_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) feed(i, 0);
      for (int i = 0; i < 40; i++) begin
         byte_ready_i = (i % 2 == 1);
         pv = byte_valid_o; pb = byte_o; pr = byte_ready_i;
         step();
         if (pv && !pr) begin
            n_checks++; if (byte_valid_o !== 1'b1 || byte_o !== pb) begin
               n_fail++; $display("FAIL bp_hold got v=%b b=%h want v=1 b=%h", byte_valid_o, byte_o, pb); end
         end
      end
      byte_ready_i = 1'b1;
      n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", got.size()); end
      else for (int i = 0; i < 8; i++) begin
         n_checks++; if (got[i] !== exp_dec[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp_dec[i]); end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      byte_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         feed(i, 0);
         if (i == 12) begin
            n_checks++; if (fifo_level_o !== 3'd4 || overflow_o !== 1'b0) begin
               n_fail++; $display("FAIL ovf_full got lvl=%0d ovf=%b want 4 0", fifo_level_o, overflow_o); end
         end
         if (i == 16) begin
            n_checks++; if (fifo_level_o !== 3'd4 || overflow_o !== 1'b1) begin
               n_fail++; $display("FAIL ovf_drop got lvl=%0d ovf=%b want 4 1", fifo_level_o, overflow_o); end
         end
      end
      clear_ovf_i = 1'b1;
      feed(20, 0);
      clear_ovf_i = 1'b0;
      n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_drop got %b want 1", overflow_o); end
      clear_ovf_i = 1'b1;
      step();
      clear_ovf_i = 1'b0;
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow_o); end
      byte_ready_i = 1'b1;
      red_q = '{0, 4, 8, 12};
      build_expected(0);
      wait_bytes(exp_q.size(), 80);
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_drain_count got %0d want %0d", got.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_drain_byte%0d got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_mode_switch();
      do_reset();
      byte_ready_i = 1'b1;
      feed(8, 0); feed(1, 1); feed(1, 1); feed(1, 1);
      feed(4, 1); feed(4, 0); feed(4, 0); feed(8, 0);
      red_q = '{8, (4 + 4 + 4 + 8) / 4};
      build_expected(0);
      wait_bytes(exp_q.size(), 40);
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL msw_count got %0d want %0d", got.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL msw_byte%0d got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_wrap_random();
      int m, s, sum, first, nfr, bad_i;
      do_reset();
      byte_ready_i = 1'b1;
      for (int g = 0; g < 257 * FS; g++) begin
         m = int'($urandom_range(0, 1));
         sum = 0; first = 0;
         for (int k = 0; k < DEC; k++) begin
            while ($urandom_range(0, 1) == 1) begin
               mode_i = 1'($urandom_range(0, 1));
               step();
            end
            s = int'($urandom_range(0, 4095));
            if (k == 0) first = s;
            sum += s;
            feed(s, (k == 0) ? m : int'($urandom_range(0, 1)));
         end
         red_q.push_back(m == 1 ? sum / 4 : first);
      end
      build_expected(0);
      wait_bytes(exp_q.size(), 300);
      nfr = exp_q.size() / FB;
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", got.size(), exp_q.size()); end
      else begin
         for (int f = 0; f < nfr; f++) begin
            bad_i = -1;
            for (int b = 0; b < FB; b++) if (bad_i < 0 && got[f * FB + b] !== exp_q[f * FB + b]) bad_i = f * FB + b;
            n_checks++; if (bad_i >= 0) begin
               n_fail++; $display("FAIL wrap_frame%0d byte %0d got %h want %h", f, bad_i, got[bad_i], exp_q[bad_i]); end
         end
         n_checks++; if (got[256 * FB + 2] !== 8'h00 || got[255 * FB + 2] !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_seq got %h/%h want ff/00", got[255 * FB + 2], got[256 * FB + 2]); end
      end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %b want 0", overflow_o); end
   endtask

   initial begin
      test_reset();
      test_decimate();
      test_average();
      test_backpressure();
      test_overflow();
      test_mode_switch();
      test_wrap_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_stream_framer.md
# adc_stream_framer

Parametrised ADC sample streamer that sits between the ADC SPI interface and the UART transmitter, replacing the fixed "send low byte of every Nth sample" path. It reduces the incoming sample stream by either decimation or power-of-two averaging, and buffers the reduced samples in a FIFO. It emits them as framed, checksummed byte packets over a valid/ready byte interface with full sample width preserved. Overflow is detected and reported rather than silently lost.

## Interface
Parameters:
- SAMPLE_W, 12, ADC sample width in bits; legal range 1..16.
- DECIM, 2000, decimation factor in mode 0; legal range ≥1.
- AVG_LOG2, 2, log2 of the group size in mode 1; legal range 0..8.
- FRAME_SAMPLES, 16, samples per frame; legal range 1..255.
- FIFO_ABITS, 4, sample FIFO depth is 2^FIFO_ABITS entries.

Ports:
- clk, in, 1, sample clock (ADC sck domain).
- rst, in, 1, reset; asynchronous, active-high.
- sample_i, in, SAMPLE_W, ADC sample data.
- sample_valid_i, in, 1, one-cycle strobe qualifying sample_i.
- mode_i, in, 1, reduction mode: 0 = decimate, 1 = average.
- clear_ovf_i, in, 1, one-cycle pulse that clears overflow_o.
- byte_o, out, 8, output byte to the UART.
- byte_valid_o, out, 1, byte_o is valid.
- byte_ready_i, in, 1, sink accepts a byte when high together with byte_valid_o.
- overflow_o, out, 1, sticky flag: a reduced sample was dropped.
- fifo_level_o, out, FIFO_ABITS+1, number of entries currently in the FIFO.

## Operation
- **Group counter.** Counts accepted sample_valid_i strobes.
  - Group size is DECIM in mode 0 and 2^AVG_LOG2 in mode 1.
  - mode_i is latched only when the group counter is 0, at the first sample of a group. A mode change mid-group takes effect at the next group.
- **Mode 0 (decimate).** The first sample of each group, indices 0, DECIM, 2·DECIM, …, is pushed to the FIFO. The remaining samples are discarded.
- **Mode 1 (average).** Accumulator width is SAMPLE_W+AVG_LOG2.
  - The first sample of a group loads the accumulator.
  - Subsequent samples add to it.
  - On the last sample, (acc+sample) >> AVG_LOG2 is pushed, truncated and never rounded.
- **FIFO.** 2^FIFO_ABITS entries of SAMPLE_W bits, first-word fall-through.
  - A push while full drops the sample and sets overflow_o.
  - A push and a pop in the same cycle while full both succeed.
- **overflow_o.** Cleared by clear_ovf_i. If a drop and a clear occur in the same cycle, overflow_o ends at 1.
- **Framer FSM.** States IDLE → SYNC0 → SYNC1 → SEQ → MSB → LSB → CSUM → IDLE.
  - IDLE exits to SYNC0 when the FIFO is non-empty.
  - SYNC0 sends 0xA5 and SYNC1 sends 0x5A.
  - SEQ sends the frame sequence number. It starts at 0, increments after each CSUM, and wraps 255→0.
  - MSB sends the sample zero-extended to 16 bits, bits [15:8]. LSB sends bits [7:0] and pops the FIFO.
  - From LSB, the FSM returns to MSB until FRAME_SAMPLES samples have been sent, then goes to CSUM.
  - In MSB with the FIFO empty, the FSM waits with byte_valid_o=0. No timeout applies.
  - CSUM sends the XOR of the SEQ byte and every sample byte of the frame. Sync bytes are excluded.
- Each state advances only on a transfer (byte_valid_o && byte_ready_i).

## Timing
- **Reset values.** byte_o=0x00, byte_valid_o=0, overflow_o=0, fifo_level_o=0. FSM in IDLE, seq=0, group counter=0, accumulator=0, latched mode=0.
- **Reset mid-operation.** Any frame in progress is abandoned, the FIFO is flushed, and no partial frame is resumed.
- **Push latency.** A qualifying sample (mode 0) or group-final sample (mode 1) at cycle N is written to the FIFO at the clk edge ending cycle N. fifo_level_o reflects it in cycle N+1.
- **IDLE exit.** FIFO non-empty in cycle N causes byte_valid_o=1 with 0xA5 in cycle N+1.
- **Outputs.** byte_o and byte_valid_o are registered. While byte_valid_o=1 and byte_ready_i=0, byte_o holds stable.
- **Back-to-back transfers.** With byte_ready_i held at 1, one byte transfers per cycle.
- **Throughput.** The sustained output is 2·FRAME_SAMPLES+4 bytes per frame. Configuring an input rate above this is legal and results in overflow.
- **Counter width.** The group counter is ⌈log2(max(DECIM, 2^AVG_LOG2))⌉+1 bits and wraps to 0 after the last index of the group.

## Test plan
Bench parameters: SAMPLE_W=12, DECIM=4, AVG_LOG2=2, FRAME_SAMPLES=2, FIFO_ABITS=2.
- **Reset.** Assert rst mid-frame → all outputs return to their reset values within the same cycle (asynchronous). After release, the next frame starts with seq=0x00.
- **Decimate.** mode 0, ramp 0x000..0x007, ready=1 → bytes A5 5A 00 00 00 00 04 04 in consecutive cycles. The final 04 is the checksum (00^00^00^00^04).
- **Average.** mode 1, samples 1,2,3,5 then 0xFFF×4 → pushed values 0x002 (11>>2) and 0xFFF. Frame: A5 5A 00 00 02 0F FF F2.
- **Backpressure.** byte_ready_i toggled 0/1 every cycle → byte_o stable while not ready, no byte duplicated or skipped, and a byte stream identical to the decimate scenario.
- **Overflow.** ready=0, 5 groups in mode 0 → fifo_level_o=4, overflow_o=1 after the 5th push. Then clear_ovf_i together with a 6th drop → overflow_o stays 1.
- **Wrap and mode switch.** Run 257 frames, then the SEQ byte of frame 257 is 0x00. Toggle mode_i mid-group → the current group completes in its latched mode.
